// File: rtl/source_pkg.sv
// Shared types for the consecutive-ones run counter.
// State encoding doubles as the output value.
package source_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        THREE = 2'd3
    } state_e;

    localparam int unsigned MAX_CNT_DEFAULT = 3;

endpackage

// File: rtl/source.sv
// Moore FSM tracking the current run of ones on x, saturated at MAX_CNT.
// Define SOURCE_DECAY_EN to make x=0 decrement the run instead of clearing it.
module source
    import source_pkg::*;
#(
    parameter int unsigned MAX_CNT = MAX_CNT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    output logic [1:0] y
);

    localparam logic [1:0] MAX_S = 2'(MAX_CNT);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ZERO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        // States above the saturation limit are illegal; recover to ZERO.
        if (state_q > MAX_S) begin
            state_d = ZERO;
        end else if (x) begin
            if (state_q != MAX_S) begin
                state_d = state_e'(state_q + 2'd1);
            end
        end else begin
`ifdef SOURCE_DECAY_EN
            if (state_q != ZERO) begin
                state_d = state_e'(state_q - 2'd1);
            end
`else
            state_d = ZERO;
`endif
        end
    end

    assign y = state_q;

endmodule

// File: tb/tb_source.sv
// Directed-vector bench for source: default build and a MAX_CNT=2 instance.
// Expected values are hand-computed for both SOURCE_DECAY_EN settings.
module tb_source;

    logic       clk;
    logic       rst;
    logic       x;
    logic [1:0] y;
    logic       rst2;
    logic       x2;
    logic [1:0] y2;

    int n_tests;
    int n_fail;

    source dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y)
    );

    source #(.MAX_CNT(2)) dut2 (
        .clk (clk),
        .rst (rst2),
        .x   (x2),
        .y   (y2)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string tag, input logic [1:0] got,
                         input logic [1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic xv, input logic rv,
                        input logic x2v, input logic r2v);
        x    = xv;
        rst  = rv;
        x2   = x2v;
        rst2 = r2v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        x    = 1'b0;
        rst  = 1'b1;
        x2   = 1'b0;
        rst2 = 1'b1;

        // reset edges at 20 and 60 ns
        step(1'b0, 1'b1, 1'b0, 1'b1); check("rst_e20", y, 2'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1); check("rst_e60", y, 2'd0);
        check("rst2_e60", y2, 2'd0);

        // alternating pattern, edges 100..260
        step(1'b0, 1'b0, 1'b0, 1'b1); check("alt_e100", y, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("alt_e140", y, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1); check("alt_e180", y, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("alt_e220", y, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1); check("alt_e260", y, 2'd0);

        // idle edges 300, 340
        step(1'b0, 1'b0, 1'b0, 1'b1); check("idle_e300", y, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1); check("idle_e340", y, 2'd0);

        // run of ones, edges 380..540, saturating at 3
        step(1'b1, 1'b0, 1'b0, 1'b1); check("run_e380", y, 2'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("run_e420", y, 2'd2);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("run_e460", y, 2'd3);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("sat_e500", y, 2'd3);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("sat_e540", y, 2'd3);

        // zeros at 580, 620
`ifdef SOURCE_DECAY_EN
        step(1'b0, 1'b0, 1'b0, 1'b1); check("zero_e580", y, 2'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1); check("zero_e620", y, 2'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("rerun_a", y, 2'd2);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("rerun_b", y, 2'd3);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("rerun_c", y, 2'd3);
`else
        step(1'b0, 1'b0, 1'b0, 1'b1); check("zero_e580", y, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1); check("zero_e620", y, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("rerun_a", y, 2'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("rerun_b", y, 2'd2);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("rerun_c", y, 2'd3);
`endif

        // mid-run reset with x=1, then release
        step(1'b1, 1'b1, 1'b0, 1'b1); check("midrst", y, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1); check("midrst_rel", y, 2'd1);
        check("rst2_hold", y2, 2'd0);

        // MAX_CNT=2 instance: four ones then a zero
        step(1'b0, 1'b0, 1'b1, 1'b0); check("m2_a", y2, 2'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0); check("m2_b", y2, 2'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0); check("m2_c", y2, 2'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0); check("m2_d", y2, 2'd2);
`ifdef SOURCE_DECAY_EN
        step(1'b0, 1'b0, 1'b0, 1'b0); check("m2_zero", y2, 2'd1);
`else
        step(1'b0, 1'b0, 1'b0, 1'b0); check("m2_zero", y2, 2'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/source.md
SOURCE -- requirements
Module: source

Interface
REQ-001 Parameter MAX_CNT, default 3, saturation limit of the run counter; legal range 1..3.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 x  input  1  serial data bit, sampled once per rising clk edge.
REQ-005 y  output  2  Moore output: current consecutive-ones run length, saturated at MAX_CNT.

Function
REQ-006 The block SHALL be a Moore FSM with four states:
- ZERO (y=0)
- ONE (y=1)
- TWO (y=2)
- THREE (y=3)
REQ-007 y SHALL be a pure function of the registered state, with no combinational path from x to y.
REQ-008 Transitions for a sampled x=1: ZERO->ONE, ONE->TWO, TWO->THREE, THREE->THREE.
- Any state whose encoding equals MAX_CNT SHALL stay put on x=1 (saturation).
REQ-009 Transitions for a sampled x=0 (SOURCE_DECAY_EN undefined): any state -> ZERO.
REQ-010 Latency: y SHALL reflect the x sampled at edge N immediately after edge N; one cycle from x change to y change.
REQ-011 States above MAX_CNT SHALL be unreachable.
- If such a state is ever entered, the next edge SHALL go to ZERO regardless of x.
REQ-012 x is synchronous to clk; no synchronizer is required.
- x SHALL be stable around the rising edge, as driven by the surrounding logic.

Reset
REQ-013 When rst=1 at a rising clk edge, the state SHALL become ZERO and y SHALL be 2'b00 after that edge, regardless of x.
REQ-014 Reset SHALL take priority over any transition, including mid-run (e.g. in state THREE with x=1).
REQ-015 While rst is held high for multiple cycles, y SHALL remain 0.
- On the first edge with rst=0, normal transitions SHALL resume from ZERO.
REQ-016 Before the first reset edge, y is undefined; no power-on value is required.

Configuration
REQ-017 Macro SOURCE_DECAY_EN: when defined, a sampled x=0 SHALL decrement the run length by one, floored at ZERO.
- THREE->TWO, TWO->ONE, ONE->ZERO, ZERO->ZERO.
- x=1 behaviour and reset SHALL be unchanged.
REQ-018 When SOURCE_DECAY_EN is undefined, REQ-009 (clear on x=0) SHALL apply.
- No decay logic SHALL be present in that build.

Structure
REQ-019 Shared package source_pkg SHALL hold:
- the 2-bit state enum typedef (ZERO=2'd0, ONE=2'd1, TWO=2'd2, THREE=2'd3);
- the constant for the default MAX_CNT.
REQ-020 The design SHALL be a single flat module with one state register and one next-state/output block; no sub-module.
REQ-021 The state encoding SHALL equal the output value, so y is driven directly from the state register.

Verification
Clock period 40 ns, rising edges at 20, 60, 100, ... ns. rst=1 until 70 ns.
REQ-022 rst=1 for edges at 20 and 60 ns with x=0 -> y=0 after both edges.
REQ-023 Alternating x=0,1,0,1,0 on edges 100..260 ns -> y sequence 0,1,0,1,0.
REQ-024 x=1 on five consecutive edges 380..540 ns -> y=1,2,3,3,3 (saturation holds at 3).
REQ-025 Then x=0 on edges 580 and 620 ns:
- without SOURCE_DECAY_EN -> y=0,0;
- with SOURCE_DECAY_EN -> y=2,1.
REQ-026 Mid-run reset: after y=3, assert rst=1 with x=1 for one edge -> y=0.
- Release rst with x=1 -> y=1 on the next edge.
REQ-027 MAX_CNT=2 with x=1 held for four edges -> y=1,2,2,2.
